wb_commit_regfile: RTL and testbench

- Write-back and commit end of the MEM/WB pipeline interface; consumes the outputs of the MEM/WB pipeline register.
- Selects the ALU result or the load data, and sign/zero-extends load data.
- Writes the 32x64 integer register file and serves two combinational read ports with same-cycle write bypass.
- Tracks retired instructions and runs the ebreak halt state machine used by simulation and difftest.

---
 rtl/wb_commit_regfile.sv | 124 ++++++++++++
 tb/tb_wb_commit_regfile.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_regfile.sv
// Write-back/commit stage: result select, load extension, 32x64 register file
// with same-cycle bypass, retire counter and the ebreak halt state machine.
module wb_commit_regfile #(
    parameter int XLEN      = 64,
    parameter int REG_NUM   = 32,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_wen_i,
    input  logic [4:0]           reg_waddr_i,
    input  logic [XLEN-1:0]      from_ex_alu_res_i,
    input  logic [XLEN-1:0]      from_mem_alu_res_i,
    input  logic [2:0]           rd_buf_flag_i,
    input  logic [3:0]           expand_signed_i,
    input  logic                 ebreak_flag_i,
    input  logic                 no_use_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic [XLEN-1:0]      rs1_data_o,
    output logic [XLEN-1:0]      rs2_data_o,
    output logic                 commit_valid_o,
    output logic [XLEN-1:0]      commit_pc_o,
    output logic [CNT_WIDTH-1:0] retire_cnt_o,
    output logic                 halt_o,
    output logic [XLEN-1:0]      exit_code_o
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]      regs_q [REG_NUM];
    logic [XLEN-1:0]      ld_ext;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      a0_byp;
    logic                 valid;
    logic                 wr_en;
    logic                 cv_q;
    logic [XLEN-1:0]      cpc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [XLEN-1:0]      exit_q;

    localparam logic [4:0] A0 = 5'd10;

    assign valid = !no_use_i && (state_q == RUN);
    assign wr_en = valid && reg_wen_i && (reg_waddr_i != 5'd0);

    always_comb begin
        ld_ext = from_mem_alu_res_i;
        case (expand_signed_i)
            4'd1: ld_ext = {{(XLEN-8){from_mem_alu_res_i[7]}},
                            from_mem_alu_res_i[7:0]};
            4'd2: ld_ext = {{(XLEN-16){from_mem_alu_res_i[15]}},
                            from_mem_alu_res_i[15:0]};
            4'd3: ld_ext = {{(XLEN-32){from_mem_alu_res_i[31]}},
                            from_mem_alu_res_i[31:0]};
            4'd4: ld_ext = {{(XLEN-8){1'b0}}, from_mem_alu_res_i[7:0]};
            4'd5: ld_ext = {{(XLEN-16){1'b0}}, from_mem_alu_res_i[15:0]};
            4'd6: ld_ext = {{(XLEN-32){1'b0}}, from_mem_alu_res_i[31:0]};
            default: ld_ext = from_mem_alu_res_i;
        endcase
        wdata = (rd_buf_flag_i == 3'd0) ? from_ex_alu_res_i : ld_ext;
    end

    // x0 reads zero; a qualifying write in this cycle is forwarded
    assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 :
                        (wr_en && rs1_addr_i == reg_waddr_i) ? wdata :
                        regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 :
                        (wr_en && rs2_addr_i == reg_waddr_i) ? wdata :
                        regs_q[rs2_addr_i];
    assign a0_byp     = (wr_en && reg_waddr_i == A0) ? wdata : regs_q[A0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[reg_waddr_i] <= wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (valid && ebreak_flag_i) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cv_q    <= 1'b0;
            cpc_q   <= '0;
            cnt_q   <= '0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            cv_q    <= valid;
            if (valid) begin
                cpc_q <= pc_i;
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            if (valid && ebreak_flag_i) begin
                exit_q <= a0_byp;
            end
        end
    end

    assign commit_valid_o = cv_q;
    assign commit_pc_o    = cpc_q;
    assign retire_cnt_o   = cnt_q;
    assign halt_o         = (state_q == HALTED);
    assign exit_code_o    = exit_q;

endmodule

// File: tb/tb_wb_commit_regfile.sv
// Directed bench for wb_commit_regfile: vector table for writes, loads and
// bypass, plus hand sequences for bubbles, ebreak halt and async reset.
module tb_wb_commit_regfile;

    logic        clk;
    logic        rst_n;
    logic        reg_wen_i;
    logic [4:0]  reg_waddr_i;
    logic [63:0] from_ex_alu_res_i;
    logic [63:0] from_mem_alu_res_i;
    logic [2:0]  rd_buf_flag_i;
    logic [3:0]  expand_signed_i;
    logic        ebreak_flag_i;
    logic        no_use_i;
    logic [63:0] pc_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [63:0] rs1_data_o;
    logic [63:0] rs2_data_o;
    logic        commit_valid_o;
    logic [63:0] commit_pc_o;
    logic [63:0] retire_cnt_o;
    logic        halt_o;
    logic [63:0] exit_code_o;

    int n_chk = 0;
    int n_fail = 0;

    wb_commit_regfile dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .reg_wen_i          (reg_wen_i),
        .reg_waddr_i        (reg_waddr_i),
        .from_ex_alu_res_i  (from_ex_alu_res_i),
        .from_mem_alu_res_i (from_mem_alu_res_i),
        .rd_buf_flag_i      (rd_buf_flag_i),
        .expand_signed_i    (expand_signed_i),
        .ebreak_flag_i      (ebreak_flag_i),
        .no_use_i           (no_use_i),
        .pc_i               (pc_i),
        .rs1_addr_i         (rs1_addr_i),
        .rs2_addr_i         (rs2_addr_i),
        .rs1_data_o         (rs1_data_o),
        .rs2_data_o         (rs2_data_o),
        .commit_valid_o     (commit_valid_o),
        .commit_pc_o        (commit_pc_o),
        .retire_cnt_o       (retire_cnt_o),
        .halt_o             (halt_o),
        .exit_code_o        (exit_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] alu;
        logic [63:0] mem;
        logic [2:0]  flag;
        logic [3:0]  code;
        logic        nu;
        logic [63:0] pc;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        ecv;
        logic [63:0] ecnt;
        logic [63:0] epc;
    } vec_t;

    vec_t v [16];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wen, input logic [4:0] wa,
                         input logic [63:0] alu, input logic nu,
                         input logic eb, input logic [63:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2);
        reg_wen_i          = wen;
        reg_waddr_i        = wa;
        from_ex_alu_res_i  = alu;
        from_mem_alu_res_i = 64'h0;
        rd_buf_flag_i      = 3'd0;
        expand_signed_i    = 4'd0;
        no_use_i           = nu;
        ebreak_flag_i      = eb;
        pc_i               = pc;
        rs1_addr_i         = r1;
        rs2_addr_i         = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] RAW_W = 64'h1234_5678_8000_0001;
    localparam logic [63:0] X3V   = 64'hFFFF_FFFF_FFFF_80F0;

    initial begin
        v[0]  = '{1'b1, 5'd5, 64'h1234, 64'h0, 3'd0, 4'd0, 1'b0, 64'h100,
                  5'd5, 5'd0, 64'h1234, 64'h0, 1'b1, 64'd1, 64'h100};
        v[1]  = '{1'b0, 5'd5, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0, 64'h104,
                  5'd5, 5'd7, 64'h1234, 64'h0, 1'b1, 64'd2, 64'h104};
        v[2]  = '{1'b1, 5'd7, 64'hDEAD, 64'h0, 3'd0, 4'd0, 1'b0, 64'h108,
                  5'd5, 5'd7, 64'h1234, 64'hDEAD, 1'b1, 64'd3, 64'h108};
        v[3]  = '{1'b1, 5'd0, 64'hFFFF, 64'h0, 3'd0, 4'd0, 1'b0, 64'h10C,
                  5'd0, 5'd7, 64'h0, 64'hDEAD, 1'b1, 64'd4, 64'h10C};
        v[4]  = '{1'b1, 5'd1, 64'h0, 64'h80F0, 3'd1, 4'd1, 1'b0, 64'h110,
                  5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0,
                  1'b1, 64'd5, 64'h110};
        v[5]  = '{1'b1, 5'd2, 64'h0, 64'h80F0, 3'd2, 4'd4, 1'b0, 64'h114,
                  5'd2, 5'd1, 64'hF0, 64'hFFFF_FFFF_FFFF_FFF0,
                  1'b1, 64'd6, 64'h114};
        v[6]  = '{1'b1, 5'd3, 64'h0, 64'h80F0, 3'd3, 4'd2, 1'b0, 64'h118,
                  5'd3, 5'd2, X3V, 64'hF0, 1'b1, 64'd7, 64'h118};
        v[7]  = '{1'b1, 5'd4, 64'h0, 64'h80F0, 3'd4, 4'd5, 1'b0, 64'h11C,
                  5'd4, 5'd3, 64'h80F0, X3V, 1'b1, 64'd8, 64'h11C};
        v[8]  = '{1'b1, 5'd6, 64'h0, RAW_W, 3'd1, 4'd3, 1'b0, 64'h120,
                  5'd6, 5'd4, 64'hFFFF_FFFF_8000_0001, 64'h80F0,
                  1'b1, 64'd9, 64'h120};
        v[9]  = '{1'b1, 5'd8, 64'h0, RAW_W, 3'd1, 4'd6, 1'b0, 64'h124,
                  5'd8, 5'd6, 64'h8000_0001, 64'hFFFF_FFFF_8000_0001,
                  1'b1, 64'd10, 64'h124};
        v[10] = '{1'b1, 5'd11, 64'h0, RAW_W, 3'd1, 4'd0, 1'b0, 64'h128,
                  5'd11, 5'd8, RAW_W, 64'h8000_0001, 1'b1, 64'd11, 64'h128};
        v[11] = '{1'b1, 5'd12, 64'h0, RAW_W, 3'd7, 4'd9, 1'b0, 64'h12C,
                  5'd12, 5'd11, RAW_W, RAW_W, 1'b1, 64'd12, 64'h12C};
        v[12] = '{1'b1, 5'd13, 64'hAA, 64'hBB, 3'd0, 4'd1, 1'b0, 64'h130,
                  5'd13, 5'd12, 64'hAA, RAW_W, 1'b1, 64'd13, 64'h130};
        v[13] = '{1'b1, 5'd3, 64'h999, 64'h0, 3'd0, 4'd0, 1'b1, 64'h134,
                  5'd3, 5'd13, X3V, 64'hAA, 1'b0, 64'd13, 64'h130};
        v[14] = '{1'b0, 5'd3, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0, 64'h138,
                  5'd3, 5'd0, X3V, 64'h0, 1'b1, 64'd14, 64'h138};
        v[15] = '{1'b1, 5'd10, 64'd42, 64'h0, 3'd0, 4'd0, 1'b0, 64'h13C,
                  5'd10, 5'd3, 64'd42, X3V, 1'b1, 64'd15, 64'h13C};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 64'h0, 5'd0, 5'd0);
        #1;
        chk("rst_cv", {63'd0, commit_valid_o}, 64'd0);
        chk("rst_cnt", retire_cnt_o, 64'd0);
        chk("rst_pc", commit_pc_o, 64'd0);
        chk("rst_halt", {63'd0, halt_o}, 64'd0);
        chk("rst_exit", exit_code_o, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            reg_wen_i          = v[i].wen;
            reg_waddr_i        = v[i].wa;
            from_ex_alu_res_i  = v[i].alu;
            from_mem_alu_res_i = v[i].mem;
            rd_buf_flag_i      = v[i].flag;
            expand_signed_i    = v[i].code;
            no_use_i           = v[i].nu;
            ebreak_flag_i      = 1'b0;
            pc_i               = v[i].pc;
            rs1_addr_i         = v[i].r1;
            rs2_addr_i         = v[i].r2;
            #1;
            chk($sformatf("v%0d_rs1", i), rs1_data_o, v[i].e1);
            chk($sformatf("v%0d_rs2", i), rs2_data_o, v[i].e2);
            tick();
            chk($sformatf("v%0d_cv", i), {63'd0, commit_valid_o},
                {63'd0, v[i].ecv});
            chk($sformatf("v%0d_cnt", i), retire_cnt_o, v[i].ecnt);
            chk($sformatf("v%0d_cpc", i), commit_pc_o, v[i].epc);
        end

        // ebreak in a bubble must be ignored
        drive(1'b0, 5'd0, 64'h0, 1'b1, 1'b1, 64'h200, 5'd10, 5'd0);
        tick();
        chk("eb_bubble_halt", {63'd0, halt_o}, 64'd0);
        chk("eb_bubble_cnt", retire_cnt_o, 64'd15);

        drive(1'b0, 5'd0, 64'h0, 1'b0, 1'b1, 64'h204, 5'd10, 5'd0);
        tick();
        chk("halt", {63'd0, halt_o}, 64'd1);
        chk("exit_code", exit_code_o, 64'd42);
        chk("halt_cnt", retire_cnt_o, 64'd16);
        chk("halt_cv", {63'd0, commit_valid_o}, 64'd1);
        chk("halt_cpc", commit_pc_o, 64'h204);

        drive(1'b1, 5'd4, 64'h5555, 1'b0, 1'b0, 64'h208, 5'd4, 5'd10);
        #1;
        chk("halted_nobyp", rs1_data_o, 64'h80F0);
        chk("halted_rs2", rs2_data_o, 64'd42);
        tick();
        tick();
        chk("halted_x4", rs1_data_o, 64'h80F0);
        chk("halted_cnt", retire_cnt_o, 64'd16);
        chk("halted_cv", {63'd0, commit_valid_o}, 64'd0);
        chk("halted_cpc", commit_pc_o, 64'h204);
        chk("halt_sticky", {63'd0, halt_o}, 64'd1);

        // reset leaves halt, then async reset in the middle of a write
        rst_n = 1'b0;
        #1;
        chk("rst2_halt", {63'd0, halt_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd9, 64'h99, 1'b0, 1'b0, 64'h300, 5'd9, 5'd5);
        tick();
        chk("x9_written", rs1_data_o, 64'h99);
        chk("x5_cleared", rs2_data_o, 64'h0);
        chk("post_rst_cnt", retire_cnt_o, 64'd1);
        drive(1'b1, 5'd9, 64'h77, 1'b0, 1'b0, 64'h304, 5'd9, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cnt", retire_cnt_o, 64'd0);
        chk("async_cv", {63'd0, commit_valid_o}, 64'd0);
        chk("async_cpc", commit_pc_o, 64'd0);
        reg_wen_i = 1'b0;
        #1;
        chk("async_x9", rs1_data_o, 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after_rst_x9", rs1_data_o, 64'd0);
        chk("after_rst_cnt", retire_cnt_o, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
